// File: rtl/video_timing_gen_if.sv
// Configuration and video-output bundle for video_timing_gen.
// The master drives staged timing fields; the slave returns status and raster outputs.
interface video_timing_gen_if #(
  parameter int CW = 12
);
  logic          cfg_wr;
  logic [CW-1:0] cfg_h_pix;
  logic [CW-1:0] cfg_h_fp;
  logic [CW-1:0] cfg_h_sync;
  logic [CW-1:0] cfg_h_bp;
  logic [CW-1:0] cfg_v_pix;
  logic [CW-1:0] cfg_v_fp;
  logic [CW-1:0] cfg_v_sync;
  logic [CW-1:0] cfg_v_bp;
  logic          cfg_pending;
  logic          cfg_err;
  logic          de;
  logic          hsync;
  logic          vsync;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          sof;
  logic          eol;

  modport master (
    output cfg_wr,
    output cfg_h_pix, cfg_h_fp, cfg_h_sync, cfg_h_bp,
    output cfg_v_pix, cfg_v_fp, cfg_v_sync, cfg_v_bp,
    input  cfg_pending, cfg_err,
    input  de, hsync, vsync, x, y, sof, eol
  );

  modport slave (
    input  cfg_wr,
    input  cfg_h_pix, cfg_h_fp, cfg_h_sync, cfg_h_bp,
    input  cfg_v_pix, cfg_v_fp, cfg_v_sync, cfg_v_bp,
    output cfg_pending, cfg_err,
    output de, hsync, vsync, x, y, sof, eol
  );
endinterface

// File: rtl/video_timing_gen.sv
// Runtime-reprogrammable raster timing generator.
// New timing is staged and only swapped in at a frame wrap.
module video_timing_gen #(
  parameter int CW     = 12,
  parameter bit HS_POL = 1'b1,
  parameter bit VS_POL = 1'b1,
  parameter int H_PIX  = 1024,
  parameter int H_FP   = 24,
  parameter int H_SYNC = 136,
  parameter int H_BP   = 160,
  parameter int V_PIX  = 600,
  parameter int V_FP   = 5,
  parameter int V_SYNC = 8,
  parameter int V_BP   = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  video_timing_gen_if.slave bus
);
  localparam int TW = CW + 2;

  typedef struct packed {
    logic [CW-1:0] h_pix;
    logic [CW-1:0] h_fp;
    logic [CW-1:0] h_sync;
    logic [CW-1:0] h_bp;
    logic [CW-1:0] v_pix;
    logic [CW-1:0] v_fp;
    logic [CW-1:0] v_sync;
    logic [CW-1:0] v_bp;
  } tim_t;

  localparam tim_t RST_T = '{
    h_pix:  CW'(H_PIX),
    h_fp:   CW'(H_FP),
    h_sync: CW'(H_SYNC),
    h_bp:   CW'(H_BP),
    v_pix:  CW'(V_PIX),
    v_fp:   CW'(V_FP),
    v_sync: CW'(V_SYNC),
    v_bp:   CW'(V_BP)
  };

  localparam logic [TW-1:0] MAXT = TW'(1) << CW;

  tim_t          a, s, cfg;
  logic          pend, err;
  logic [CW-1:0] hc, vc;
  logic [TW-1:0] ht, vt, nht, nvt;
  logic [TW-1:0] hs0, hs1, vs0, vs1;
  logic [TW-1:0] hcw, vcw;
  logic          h_end, v_end, wrap;
  logic          cfg_ok, acc;
  logic          de_q, hs_q, vs_q, sof_q, eol_q;
  logic [CW-1:0] x_q, y_q;

  // Totals, sync windows and validation of the incoming fields
  always_comb begin
    cfg        = '0;
    cfg.h_pix  = bus.cfg_h_pix;
    cfg.h_fp   = bus.cfg_h_fp;
    cfg.h_sync = bus.cfg_h_sync;
    cfg.h_bp   = bus.cfg_h_bp;
    cfg.v_pix  = bus.cfg_v_pix;
    cfg.v_fp   = bus.cfg_v_fp;
    cfg.v_sync = bus.cfg_v_sync;
    cfg.v_bp   = bus.cfg_v_bp;
    ht  = TW'(a.h_pix) + TW'(a.h_fp) + TW'(a.h_sync) + TW'(a.h_bp);
    vt  = TW'(a.v_pix) + TW'(a.v_fp) + TW'(a.v_sync) + TW'(a.v_bp);
    nht = TW'(cfg.h_pix) + TW'(cfg.h_fp)
        + TW'(cfg.h_sync) + TW'(cfg.h_bp);
    nvt = TW'(cfg.v_pix) + TW'(cfg.v_fp)
        + TW'(cfg.v_sync) + TW'(cfg.v_bp);
    hs0 = TW'(a.h_pix) + TW'(a.h_fp);
    hs1 = hs0 + TW'(a.h_sync);
    vs0 = TW'(a.v_pix) + TW'(a.v_fp);
    vs1 = vs0 + TW'(a.v_sync);
    hcw = TW'(hc);
    vcw = TW'(vc);
    h_end  = (hcw == ht - TW'(1));
    v_end  = (vcw == vt - TW'(1));
    wrap   = en && h_end && v_end;
    cfg_ok = (|cfg.h_pix) && (|cfg.v_pix)
          && (|cfg.h_sync) && (|cfg.v_sync)
          && (nht <= MAXT) && (nvt <= MAXT);
    acc    = bus.cfg_wr && cfg_ok;
  end

  // Staging, frame-boundary apply and raster counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a    <= RST_T;
      s    <= RST_T;
      pend <= 1'b0;
      err  <= 1'b0;
      hc   <= '0;
      vc   <= '0;
    end else begin
      err <= bus.cfg_wr && !cfg_ok;
      if (acc) s <= cfg;
      if (wrap && pend) a <= s;
      if (acc) pend <= 1'b1;
      else if (wrap) pend <= 1'b0;
      if (en) begin
        if (h_end) begin
          hc <= '0;
          vc <= v_end ? '0 : vc + CW'(1);
        end else begin
          hc <= hc + CW'(1);
        end
      end
    end
  end

  // Registered decode of the current counter position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q  <= 1'b0;
      hs_q  <= !HS_POL;
      vs_q  <= !VS_POL;
      sof_q <= 1'b0;
      eol_q <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      de_q  <= en && (hcw < TW'(a.h_pix)) && (vcw < TW'(a.v_pix));
      hs_q  <= (en && hcw >= hs0 && hcw < hs1) ? HS_POL : !HS_POL;
      vs_q  <= (en && vcw >= vs0 && vcw < vs1) ? VS_POL : !VS_POL;
      sof_q <= en && (hc == '0) && (vc == '0);
      eol_q <= en && h_end;
      if (en) begin
        x_q <= hc;
        y_q <= vc;
      end
    end
  end

  assign bus.cfg_pending = pend;
  assign bus.cfg_err     = err;
  assign bus.de          = de_q;
  assign bus.hsync       = hs_q;
  assign bus.vsync       = vs_q;
  assign bus.sof         = sof_q;
  assign bus.eol         = eol_q;
  assign bus.x           = x_q;
  assign bus.y           = y_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: default-geometry instance
// plus a small-geometry, active-low-sync instance for mode switches.
module tb_video_timing_gen;
  logic clk;
  logic rst_n;
  logic en0, en1;
  int   n_cmp, n_bad;

  video_timing_gen_if #(.CW(12)) b0 ();
  video_timing_gen_if #(.CW(12)) b1 ();

  video_timing_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en0),
    .bus   (b0)
  );

  video_timing_gen #(
    .CW(12), .HS_POL(1'b0), .VS_POL(1'b0),
    .H_PIX(6), .H_FP(1), .H_SYNC(1), .H_BP(2),
    .V_PIX(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dus (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en1),
    .bus   (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int n);
    repeat (n) tick();
  endtask

  task automatic cfg0(input logic wr,
                      input int hp, input int hf, input int hs, input int hb,
                      input int vp, input int vf, input int vs, input int vb);
    b0.cfg_wr     = wr;
    b0.cfg_h_pix  = 12'(hp);
    b0.cfg_h_fp   = 12'(hf);
    b0.cfg_h_sync = 12'(hs);
    b0.cfg_h_bp   = 12'(hb);
    b0.cfg_v_pix  = 12'(vp);
    b0.cfg_v_fp   = 12'(vf);
    b0.cfg_v_sync = 12'(vs);
    b0.cfg_v_bp   = 12'(vb);
  endtask

  task automatic cfg1(input logic wr,
                      input int hp, input int hf, input int hs, input int hb,
                      input int vp, input int vf, input int vs, input int vb);
    b1.cfg_wr     = wr;
    b1.cfg_h_pix  = 12'(hp);
    b1.cfg_h_fp   = 12'(hf);
    b1.cfg_h_sync = 12'(hs);
    b1.cfg_h_bp   = 12'(hb);
    b1.cfg_v_pix  = 12'(vp);
    b1.cfg_v_fp   = 12'(vf);
    b1.cfg_v_sync = 12'(vs);
    b1.cfg_v_bp   = 12'(vb);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    en0   = 1'b0;
    en1   = 1'b0;
    cfg0(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    cfg1(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    // reset state: {de,hsync,vsync,sof,eol,pending,err}
    chk("rst_flags0", {b0.de, b0.hsync, b0.vsync, b0.sof, b0.eol,
                       b0.cfg_pending, b0.cfg_err}, 7'b0000000);
    chk("rst_xy0", {b0.x, b0.y}, 24'd0);
    chk("rst_flags1", {b1.de, b1.hsync, b1.vsync, b1.sof, b1.eol,
                       b1.cfg_pending, b1.cfg_err}, 7'b0110000);

    // default 1344x628 geometry, first line
    @(negedge clk);
    rst_n = 1'b1;
    en0   = 1'b1;
    tick();
    chk("first_sof", b0.sof, 1);
    chk("first_de", b0.de, 1);
    chk("first_xy", {b0.x, b0.y}, 24'd0);
    go(1023);
    chk("x1023", b0.x, 1023);
    chk("de_x1023", b0.de, 1);
    go(1);
    chk("de_x1024", b0.de, 0);
    go(23);
    chk("hs_x1047", b0.hsync, 0);
    go(1);
    chk("hs_x1048", b0.hsync, 1);
    go(135);
    chk("hs_x1183", b0.hsync, 1);
    go(1);
    chk("hs_x1184", b0.hsync, 0);
    go(159);
    chk("eol_x1343", b0.eol, 1);
    chk("x1343", b0.x, 1343);
    go(1);
    chk("line1_xy", {b0.x, b0.y}, {12'd0, 12'd1});
    chk("line1_sof", b0.sof, 0);
    chk("line1_eol", b0.eol, 0);

    // pause at x=500, y=10
    go(12596);
    chk("pause_xy", {b0.x, b0.y}, {12'd500, 12'd10});
    chk("pause_de", b0.de, 1);
    en0 = 1'b0;
    go(10);
    chk("idle_flags", {b0.de, b0.hsync, b0.vsync, b0.sof, b0.eol},
        5'b00000);
    chk("idle_xy", {b0.x, b0.y}, {12'd500, 12'd10});
    en0 = 1'b1;
    tick();
    chk("resume_x", b0.x, 501);
    chk("resume_de", b0.de, 1);
    go(842);
    chk("resume_eol", b0.eol, 1);
    chk("resume_x1343", b0.x, 1343);
    go(1);
    chk("resume_wrap", {b0.x, b0.y}, {12'd0, 12'd11});

    // rejected writes: h_sync=0, then HT=4097
    cfg0(1'b1, 4, 1, 0, 1, 3, 1, 1, 1);
    tick();
    chk("err_hs0", b0.cfg_err, 1);
    chk("err_hs0_pend", b0.cfg_pending, 0);
    cfg0(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("err_hs0_clr", b0.cfg_err, 0);
    chk("err_hs0_xy", {b0.x, b0.y}, {12'd2, 12'd11});
    cfg0(1'b1, 4000, 50, 40, 7, 3, 1, 1, 1);
    tick();
    chk("err_ht4097", b0.cfg_err, 1);
    cfg0(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("err_ht_clr", {b0.cfg_err, b0.cfg_pending}, 2'b00);
    // HT=4096 is the largest legal total
    cfg0(1'b1, 4000, 50, 40, 6, 3, 1, 1, 1);
    tick();
    chk("ok_ht4096", {b0.cfg_err, b0.cfg_pending}, 2'b01);
    cfg0(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    go(1018);
    chk("pend_x1023", b0.x, 1023);
    chk("pend_de", b0.de, 1);
    go(320);
    chk("pend_old_eol", b0.eol, 1);
    chk("pend_still", b0.cfg_pending, 1);

    // asynchronous reset mid-frame discards the staged config
    rst_n = 1'b0;
    #2;
    chk("arst_flags", {b0.de, b0.hsync, b0.vsync, b0.sof, b0.eol,
                       b0.cfg_pending, b0.cfg_err}, 7'b0000000);
    chk("arst_xy", {b0.x, b0.y}, 24'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rerun_sof", b0.sof, 1);
    go(1343);
    chk("rerun_eol", b0.eol, 1);
    chk("rerun_xy", {b0.x, b0.y}, {12'd1343, 12'd0});
    chk("rerun_pend", b0.cfg_pending, 0);

    // small instance: HT=10, VT=7, active-low syncs
    en1 = 1'b1;
    tick();
    chk("s_sof", {b1.sof, b1.de, b1.hsync, b1.vsync}, 4'b1111);
    go(7);
    chk("s_hs_x7", b1.hsync, 0);
    go(1);
    chk("s_hs_x8", b1.hsync, 1);
    go(1);
    chk("s_eol_x9", b1.eol, 1);
    cfg1(1'b1, 4, 1, 2, 1, 3, 1, 1, 1);
    tick();
    chk("s_pend", {b1.cfg_pending, b1.cfg_err}, 2'b10);
    chk("s_pend_xy", {b1.x, b1.y}, {12'd0, 12'd1});
    cfg1(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    go(45);
    chk("s_old_vs", {b1.x, b1.y, b1.vsync, b1.de},
        {12'd5, 12'd5, 1'b0, 1'b0});
    go(13);
    chk("s_pre_wrap", {b1.x, b1.y, b1.cfg_pending},
        {12'd8, 12'd6, 1'b1});
    go(1);
    chk("s_wrap", {b1.eol, b1.cfg_pending}, 2'b10);

    // new mode: HT=8, VT=6
    tick();
    chk("n_sof", {b1.sof, b1.de, b1.x, b1.y}, {2'b11, 24'd0});
    go(3);
    chk("n_de_x3", b1.de, 1);
    go(1);
    chk("n_x4", {b1.de, b1.hsync}, 2'b01);
    go(1);
    chk("n_hs_x5", b1.hsync, 0);
    go(1);
    chk("n_hs_x6", b1.hsync, 0);
    go(1);
    chk("n_x7", {b1.hsync, b1.eol, b1.x}, {2'b11, 12'd7});
    go(17);
    chk("n_y3_de", {b1.de, b1.x, b1.y}, {1'b0, 12'd0, 12'd3});
    go(7);
    chk("n_vs_y3", b1.vsync, 1);
    go(1);
    chk("n_vs_y4", {b1.vsync, b1.y}, {1'b0, 12'd4});
    go(7);
    chk("n_vs_y4e", b1.vsync, 0);
    go(1);
    chk("n_vs_y5", b1.vsync, 1);
    go(7);
    chk("n_last", {b1.sof, b1.eol}, 2'b01);
    go(1);
    chk("n_sof48", {b1.sof, b1.x, b1.y}, {1'b1, 24'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
